alu_execute_unit: RTL
=====================

// Module: alu_execute_unit
// PURPOSE
//  Execute stage downstream of the R-type control decoder. Consumes the decoded
//  4-bit alu_control code, the regwrite_control flag, the destination register
//  and two operands. Performs single-cycle logic/arith/shift ops and an
//  iterative shift-add MUL. Presents one writeback beat per accepted op, with a
//  valid/ready handshake on the input side.
// PARAMETERS
//  WIDTH         32  operand/result width; power of 2, >= 8
//  MUL_BITS      1   multiplier bits retired per MUL cycle; 1, 2 or 4; divides WIDTH
// PORTS
//  clock             in   1      rising-edge clock
//  reset_n           in   1      asynchronous, active-low reset
//  in_valid          in   1      op presented this cycle
//  in_ready          out  1      unit can accept an op this cycle
//  alu_control       in   4      decoded op code (see BEHAVIOUR)
//  regwrite_control  in   1      op writes the register file
//  rd_addr           in   5      destination register
//  operand_a         in   WIDTH  rs1 value
//  operand_b         in   WIDTH  rs2 value
//  wb_valid          out  1      writeback beat; one-cycle pulse per op
//  wb_en             out  1      register-file write enable, qualified by wb_valid
//  wb_addr           out  5      destination register for the beat
//  wb_data           out  WIDTH  result
//  illegal_op        out  1      pulses with wb_valid when the code is undefined
//  busy              out  1      high in MUL state
// BEHAVIOUR
//  - Reset: single clock, async active-low reset. All outputs 0 (in_ready=0
//    while reset_n=0, 1 from the first clock after release); state=IDLE;
//    all internal registers cleared.
//  - Codes: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SUB, 0101 SRL,
//    0110 MUL, 0111 XOR. 1xxx is illegal.
//  - Arithmetic: ADD/SUB wrap modulo 2^WIDTH. Shift amount is
//    operand_b[log2(WIDTH)-1:0]; SRL is logical. MUL returns the low WIDTH
//    bits of the product, signedness-agnostic.
//  - Accept occurs when in_valid & in_ready at a rising edge. All inputs are
//    captured then; they are don't-care afterward.
//  - States: IDLE, MUL, WB. in_ready = (state != MUL).
//    IDLE/WB + accept non-MUL -> WB (result registered).
//    IDLE/WB + accept MUL -> MUL.
//    WB with no accept -> IDLE.
//    MUL after WIDTH/MUL_BITS cycles -> WB.
//  - Latency, non-MUL: accept at edge N -> wb_valid high during cycle N+1.
//    Back-to-back accepts in WB give one beat per cycle.
//  - Latency, MUL: accept at edge N -> wb_valid in cycle N+1+WIDTH/MUL_BITS.
//    busy=1 and in_ready=0 for all MUL cycles.
//  - wb_en = wb_valid & regwrite_control & legal & (rd_addr != 0).
//    Writes to x0 are always suppressed. wb_data still carries the result.
//  - Illegal code: single-cycle path. wb_valid=1, wb_en=0, wb_data=0,
//    illegal_op=1.
//  - wb_* outputs are registered. They hold their last values outside a beat;
//    only wb_valid, wb_en and illegal_op return to 0.
//  - Reset asserted mid-MUL aborts the op: no wb_valid is ever produced for it.
// TESTING
//  - ADD a=5 b=7 rd=3 regwrite=1 -> next cycle wb_valid=1 wb_en=1 wb_addr=3
//    wb_data=12.
//  - SUB a=3 b=5 -> wb_data=0xFFFFFFFE. SLL a=1 b=0x25 -> wb_data=0x20.
//    SRL a=0x80000000 b=31 -> wb_data=1.
//  - MUL a=0x0000FFFF b=0x00010001 (WIDTH=32, MUL_BITS=1) -> in_ready=0 and
//    busy=1 for 32 cycles; wb_data=0xFFFFFFFF in cycle N+33.
//  - Code 4'b1000 -> illegal_op=1 wb_valid=1 wb_en=0 wb_data=0.
//    ADD with rd=0 -> wb_valid=1 wb_en=0.
//  - Three ADDs with in_valid held high -> three consecutive wb_valid beats.
//    An ADD then a MUL with in_valid held -> in_ready drops after the MUL
//    accept.
//  - reset_n low 10 cycles into a MUL -> outputs 0 immediately; after release
//    there is no wb_valid and in_ready=1.

Source files
------------

// File: rtl/alu_execute_unit_if.sv
// Op-issue and writeback bundle for the ALU execute stage; the decoder side drives
// through master, the execute unit sits on slave.
interface alu_execute_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic             regwrite_control;
    logic [4:0]       rd_addr;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             wb_valid;
    logic             wb_en;
    logic [4:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic             illegal_op;
    logic             busy;

    modport master (
        output in_valid, alu_control, regwrite_control, rd_addr, operand_a, operand_b,
        input  in_ready, wb_valid, wb_en, wb_addr, wb_data, illegal_op, busy
    );

    modport slave (
        input  in_valid, alu_control, regwrite_control, rd_addr, operand_a, operand_b,
        output in_ready, wb_valid, wb_en, wb_addr, wb_data, illegal_op, busy
    );
endinterface

// File: rtl/alu_execute_unit.sv
// ALU execute stage: single-cycle logic/arith/shift ops, iterative shift-add MUL; 1 cycle, or 1+WIDTH/MUL_BITS for MUL.
// Backpressure: in_ready is low for every MUL cycle; writeback is a pulse with no downstream stall.
module alu_execute_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    alu_execute_unit_if.slave  io
);
    localparam int         SH_W      = $clog2(WIDTH);
    localparam int         MUL_STEPS = WIDTH / MUL_BITS;
    localparam int         CNT_W     = $clog2(MUL_STEPS);
    localparam logic [3:0] OP_MUL    = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       rw;
    } dest_t;

    state_t           state_q;
    logic             ready_q;
    logic             busy_q;
    logic             wb_valid_q;
    logic             wb_en_q;
    logic             illegal_q;
    logic [4:0]       wb_addr_q;
    logic [WIDTH-1:0] wb_data_q;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    dest_t            dest_q;

    logic             accept;
    logic             op_legal;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] pp;

    assign accept   = io.in_valid & ready_q;
    assign op_legal = ~io.alu_control[3];
    assign shamt    = io.operand_b[SH_W-1:0];

    assign io.in_ready   = ready_q;
    assign io.busy       = busy_q;
    assign io.wb_valid   = wb_valid_q;
    assign io.wb_en      = wb_en_q;
    assign io.wb_addr    = wb_addr_q;
    assign io.wb_data    = wb_data_q;
    assign io.illegal_op = illegal_q;

    always_comb begin
        alu_res = '0;
        case (io.alu_control[2:0])
            3'b000:  alu_res = io.operand_a & io.operand_b;
            3'b001:  alu_res = io.operand_a | io.operand_b;
            3'b010:  alu_res = io.operand_a + io.operand_b;
            3'b011:  alu_res = io.operand_a << shamt;
            3'b100:  alu_res = io.operand_a - io.operand_b;
            3'b101:  alu_res = io.operand_a >> shamt;
            3'b111:  alu_res = io.operand_a ^ io.operand_b;
            default: alu_res = '0;
        endcase
    end

    // One multiplier digit per cycle: add the shifted multiplicand for each set bit.
    always_comb begin
        pp = '0;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (mplier_q[j]) pp = pp + (mcand_q << j);
        end
        acc_d    = acc_q + pp;
        mcand_d  = mcand_q << MUL_BITS;
        mplier_d = mplier_q >> MUL_BITS;
        cnt_d    = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            illegal_q  <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            dest_q     <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            illegal_q  <= 1'b0;
            case (state_q)
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_d;
                    if (cnt_q == '0) begin
                        state_q    <= S_WB;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_en_q    <= dest_q.rw && (dest_q.rd != 5'd0);
                        wb_addr_q  <= dest_q.rd;
                        wb_data_q  <= acc_d;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    if (!accept) begin
                        state_q <= S_IDLE;
                    end else if (io.alu_control == OP_MUL) begin
                        state_q  <= S_MUL;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        acc_q    <= '0;
                        mcand_q  <= io.operand_a;
                        mplier_q <= io.operand_b;
                        cnt_q    <= CNT_W'(MUL_STEPS - 1);
                        dest_q   <= '{rd: io.rd_addr, rw: io.regwrite_control};
                    end else begin
                        state_q    <= S_WB;
                        wb_valid_q <= 1'b1;
                        wb_en_q    <= io.regwrite_control && op_legal && (io.rd_addr != 5'd0);
                        wb_addr_q  <= io.rd_addr;
                        wb_data_q  <= op_legal ? alu_res : '0;
                        illegal_q  <= ~op_legal;
                    end
                end
            endcase
        end
    end
endmodule
